// File: rtl/i2s_rx_if.sv
// Parallel stereo sample bus from i2s_rx to its consumer (dsp_engine input side).
interface i2s_rx_if #(
  parameter int DATA_W = 24
);
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_l;
  logic signed [DATA_W-1:0] out_r;
  logic                     frame_err;

  modport master (output out_valid, output out_l, output out_r, output frame_err);
  modport slave  (input  out_valid, input  out_l, input  out_r, input  frame_err);
endinterface

// File: rtl/i2s_rx.sv
// Oversampling I2S receiver: bclk/lrck/sdata sampled on the system clock, stereo pairs out.
// Optional macro I2S_RX_LJ_EN enables left-justified timing selected by fmt_lj.
module i2s_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 24,
  parameter int MIN_BITS    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enable,
  input  logic     fmt_lj,
  input  logic     i2s_bclk,
  input  logic     i2s_lrck,
  input  logic     i2s_sdata,
  i2s_rx_if.master smp
);

  localparam logic [5:0] DATA_CNT = 6'(DATA_W);
  localparam logic [5:0] MIN_CNT  = 6'(MIN_BITS);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LEFT, S_RIGHT} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0]   bclk_sync, lrck_sync, sdata_sync;
  logic                     bclk_p0, lrck_p0, sdata_p0, bclk_q_p0, rise_p0;
  logic                     ws_d, slot_q, slot_cur, bnd, fmt_chg;
  logic [DATA_W-1:0]        shreg_p1, left_buf_p1;
  logic [5:0]               cnt_p1;
  logic                     emit, err, latch_l;
  logic                     vld_p2, err_p2;
  logic signed [DATA_W-1:0] out_l_p2, out_r_p2;

  // Short slots are left-aligned so the captured MSB lands in the output MSB.
  function automatic logic [DATA_W-1:0] align_left(input logic [DATA_W-1:0] sh,
                                                   input logic [5:0]        n);
    if (n >= DATA_CNT) return sh;
    return sh << (DATA_CNT - n);
  endfunction

  // Stage p0: synchronisers and bclk rise detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bclk_q_p0  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
      bclk_q_p0  <= bclk_p0;
    end
  end

  assign bclk_p0  = bclk_sync[SYNC_STAGES-1];
  assign lrck_p0  = lrck_sync[SYNC_STAGES-1];
  assign sdata_p0 = sdata_sync[SYNC_STAGES-1];
  assign rise_p0  = bclk_p0 & ~bclk_q_p0;

`ifdef I2S_RX_LJ_EN
  logic fmt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   fmt_q <= 1'b0;
    else if (state == S_IDLE || state == S_SYNC)  fmt_q <= fmt_lj;
  end
  assign slot_cur = fmt_q ? lrck_p0 : ws_d;
  assign fmt_chg  = (state == S_LEFT || state == S_RIGHT) && (fmt_lj != fmt_q);
`else
  logic unused_fmt;
  assign unused_fmt = fmt_lj;
  assign slot_cur   = ws_d;
  assign fmt_chg    = 1'b0;
`endif

  assign bnd = rise_p0 && (slot_cur != slot_q);

  // Slot tracking runs even in IDLE so the first boundary seen in SYNC is genuine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_d   <= 1'b0;
      slot_q <= 1'b0;
    end else if (rise_p0) begin
      ws_d   <= lrck_p0;
      slot_q <= slot_cur;
    end
  end

  // Stage p1: slot capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_p1 <= '0;
      cnt_p1   <= '0;
    end else if (state == S_IDLE) begin
      shreg_p1 <= '0;
      cnt_p1   <= '0;
    end else if (bnd) begin
      shreg_p1 <= {{(DATA_W-1){1'b0}}, sdata_p0};
      cnt_p1   <= 6'd1;
    end else if (rise_p0) begin
      if (cnt_p1 < DATA_CNT) shreg_p1 <= {shreg_p1[DATA_W-2:0], sdata_p0};
      if (cnt_p1 != 6'd63)   cnt_p1   <= cnt_p1 + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    err      = 1'b0;
    latch_l  = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nx = S_SYNC;
        S_SYNC: if (bnd && !slot_cur) state_nx = S_LEFT;
        S_LEFT: begin
          if (fmt_chg) state_nx = S_SYNC;
          else if (bnd) begin
            if (cnt_p1 < MIN_CNT) begin
              err      = 1'b1;
              state_nx = S_SYNC;
            end else begin
              latch_l  = 1'b1;
              state_nx = S_RIGHT;
            end
          end
        end
        S_RIGHT: begin
          if (fmt_chg) state_nx = S_SYNC;
          else if (bnd) begin
            // This boundary is a left start either way, so capture resumes at once.
            if (cnt_p1 < MIN_CNT) err  = 1'b1;
            else                  emit = 1'b1;
            state_nx = S_LEFT;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       left_buf_p1 <= '0;
    else if (latch_l) left_buf_p1 <= align_left(shreg_p1, cnt_p1);
  end

  // Stage p2: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      out_l_p2 <= '0;
      out_r_p2 <= '0;
    end else begin
      vld_p2 <= emit;
      err_p2 <= err;
      if (emit) begin
        out_l_p2 <= left_buf_p1;
        out_r_p2 <= align_left(shreg_p1, cnt_p1);
      end
    end
  end

  assign smp.out_valid = vld_p2;
  assign smp.frame_err = err_p2;
  assign smp.out_l     = out_l_p2;
  assign smp.out_r     = out_r_p2;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit-level I2S stream generator plus output pulse monitor.
module tb_i2s_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic fmt_lj = 1'b0;
  logic bclk = 1'b0;
  logic lrck = 1'b0;
  logic sdata = 1'b0;

  i2s_rx_if #(.DATA_W(24)) bus ();

  i2s_rx #(.SYNC_STAGES(2), .DATA_W(24), .MIN_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fmt_lj    (fmt_lj),
    .i2s_bclk  (bclk),
    .i2s_lrck  (lrck),
    .i2s_sdata (sdata),
    .smp       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nval = 0, nhigh = 0, nerr = 0;
  bit prev_v = 1'b0;
  bit lj_mode = 1'b0;
  bit q_s[$];
  bit q_d[$];
  int v0, h0, e0;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      nhigh++;
      if (!prev_v) nval++;
    end
    if (bus.frame_err) nerr++;
    prev_v = bus.out_valid;
  end

  task automatic add_slot(input bit s, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      q_s.push_back(s);
      q_d.push_back(v[31-i]);
    end
  endtask

  // One bit per 8 clks; lrck runs one bit ahead in I2S timing.
  task automatic play();
    for (int k = 0; k < q_s.size(); k++) begin
      @(negedge clk);
      bclk  = 1'b0;
      sdata = q_d[k];
      if (lj_mode || k + 1 >= q_s.size()) lrck = q_s[k];
      else                                lrck = q_s[k+1];
      repeat (3) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    q_s.delete();
    q_d.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic flush();
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    v0 = nval; h0 = nhigh; e0 = nerr;
  endtask

  task automatic check_counts(input string nm, input int dv, input int de);
    total++;
    if (nval - v0 !== dv) begin
      bad++; $display("FAIL %s_valid_count: got %0d want %0d", nm, nval - v0, dv);
    end
    total++;
    if (nhigh - h0 !== dv) begin
      bad++; $display("FAIL %s_valid_width: got %0d high clks want %0d", nm, nhigh - h0, dv);
    end
    total++;
    if (nerr - e0 !== de) begin
      bad++; $display("FAIL %s_err_count: got %0d want %0d", nm, nerr - e0, de);
    end
  endtask

  task automatic check_out(input string nm, input logic [23:0] el, input logic [23:0] er);
    total++;
    if (bus.out_l !== el) begin
      bad++; $display("FAIL %s_out_l: got %h want %h", nm, bus.out_l, el);
    end
    total++;
    if (bus.out_r !== er) begin
      bad++; $display("FAIL %s_out_r: got %h want %h", nm, bus.out_r, er);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.out_valid, bus.frame_err} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b want 00", {bus.out_valid, bus.frame_err});
    end
    check_out("reset", 24'h000000, 24'h000000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_i2s_32();
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h12345600, 32);
    add_slot(1'b1, 32'hABCDEF00, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("i2s32", 1, 0);
    check_out("i2s32", 24'h123456, 24'hABCDEF);
  endtask

  task automatic test_back_to_back_16();
    flush();
    add_slot(1'b1, 32'h0, 4);
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, 32'h80010000, 16);
      add_slot(1'b1, 32'h7FFF0000, 16);
    end
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("b2b16", 4, 0);
    check_out("b2b16", 24'h800100, 24'h7FFF00);
  endtask

  task automatic test_mid_slot_start();
    flush();
    add_slot(1'b1, 32'hFFC00000, 10);
    add_slot(1'b0, 32'h13579000, 32);
    add_slot(1'b1, 32'h2468AC00, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("midslot", 1, 0);
    check_out("midslot", 24'h135790, 24'h2468AC);
  endtask

  task automatic test_short_right();
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h55AA3300, 32);
    add_slot(1'b1, 32'hFF000000, 8);
    add_slot(1'b0, 32'h0F0F0F00, 32);
    add_slot(1'b1, 32'hF0F0F000, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("shortr", 1, 1);
    check_out("shortr", 24'h0F0F0F, 24'hF0F0F0);
  endtask

  task automatic test_min_bits();
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h7FFF0000, 15);
    add_slot(1'b1, 32'h11111100, 32);
    add_slot(1'b0, 32'h65432100, 32);
    add_slot(1'b1, 32'h0FEDCB00, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("minbits", 1, 1);
    check_out("minbits", 24'h654321, 24'h0FEDCB);
  endtask

  task automatic test_enable_drop();
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'hDEADBE00, 12);
    play();
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check_counts("endrop_cut", 0, 0);
    check_out("endrop_hold", 24'h654321, 24'h0FEDCB);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h0A0B0C00, 32);
    add_slot(1'b1, 32'h0D0E0F00, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("endrop_resume", 1, 0);
    check_out("endrop_resume", 24'h0A0B0C, 24'h0D0E0F);
  endtask

  task automatic test_async_reset();
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h13579B00, 32);
    add_slot(1'b1, 32'hFFFFFF00, 10);
    play();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.frame_err} !== 2'b00) begin
      bad++; $display("FAIL arst_flags: got %b want 00", {bus.out_valid, bus.frame_err});
    end
    check_out("arst", 24'h000000, 24'h000000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    v0 = nval; h0 = nhigh; e0 = nerr;
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h0C0FFE00, 32);
    add_slot(1'b1, 32'h0BEEF000, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("arst_recover", 1, 0);
    check_out("arst_recover", 24'h0C0FFE, 24'h0BEEF0);
  endtask

`ifdef I2S_RX_LJ_EN
  task automatic test_lj();
    @(negedge clk);
    enable = 1'b0;
    fmt_lj = 1'b1;
    lj_mode = 1'b1;
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_slot(1'b0, 32'h00000100, 32);
    add_slot(1'b1, 32'hFFFFFF00, 32);
    add_slot(1'b0, 32'h0, 2);
    play();
    check_counts("lj", 1, 0);
    check_out("lj", 24'h000001, 24'hFFFFFF);
    enable = 1'b0;
    fmt_lj = 1'b0;
    lj_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_i2s_32();
    test_back_to_back_16();
    test_mid_slot_start();
    test_short_right();
    test_min_bits();
    test_enable_drop();
    test_async_reset();
`ifdef I2S_RX_LJ_EN
    test_lj();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Serial audio receiver that feeds dsp_engine directly: converts an external I2S (optionally left-justified) stream into parallel stereo 24-bit samples.
- Drives dsp_engine's in_valid/in_l/in_r.
- Runs entirely on the system clock: BCLK, LRCK and SDATA are oversampled after synchronisers; no second clock domain inside the block.
- Requires clk frequency ≥ 4× BCLK frequency.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on i2s_bclk, i2s_lrck, i2s_sdata (min 2).
- DATA_W, 24: output sample width; bits captured per slot.
- MIN_BITS, 16: minimum slot length in BCLKs; shorter slots are frame errors.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  receiver enable; low flushes to IDLE.
- fmt_lj  in  1  1 = left-justified, 0 = I2S. Honoured only with I2S_RX_LJ_EN.
- i2s_bclk  in  1  external bit clock, asynchronous.
- i2s_lrck  in  1  word select: 0 = left, 1 = right.
- i2s_sdata  in  1  serial data, MSB first.
- out_valid  out  1  one-clk pulse; new stereo pair on out_l/out_r.
- out_l  out  DATA_W  left sample, two's complement.
- out_r  out  DATA_W  right sample, two's complement.
- frame_err  out  1  one-clk pulse when a frame is dropped.

Behaviour:
- Reset values: out_valid=0, out_l=0, out_r=0, frame_err=0, FSM=IDLE, all shift/count registers 0.
- Asynchronous reset mid-frame clears everything immediately; the partial frame is lost.

Sampling:
- All three inputs pass through SYNC_STAGES flops.
- A BCLK rise is sync_bclk 0→1 between consecutive clks.
- All sampling occurs only on BCLK-rise clks.

Slot association:
- I2S mode: a data bit belongs to the slot given by the LRCK value sampled at the previous BCLK rise (ws_d). This implements the one-bit delay.
- LJ mode: the slot is given by the LRCK value at the current rise.
- A slot boundary is a change of the slot value between consecutive BCLK rises.

Capture:
- Within a slot, the first DATA_W bits shift in MSB first. Later bits are ignored.
- A bit counter saturates at 63.
- A slot with fewer than DATA_W but at least MIN_BITS bits is left-aligned with LSBs zero-padded (e.g. 16-bit 0x8001 → 0x800100).

FSM states:
- IDLE: entered on reset or while enable=0. Transitions to SYNC when enable=1.
- SYNC: discards bits until the first boundary into a left slot, then goes to LEFT. Partial slots are never emitted.
- LEFT: captures the left slot. At the right boundary, latch left_buf and go to RIGHT.
- RIGHT: captures the right slot. At the next left boundary, the pair is complete; go to LEFT to start capturing the new left slot at the same rise.

Output:
- One clk after the completing BCLK-rise clk: out_valid=1 for exactly one clk, and out_l/out_r update simultaneously.
- out_l/out_r hold their values until the next update.

Errors:
- If a left or right slot has count < MIN_BITS at its boundary, pulse frame_err one clk after the boundary clk.
- The pair is discarded, no out_valid is issued, and the FSM goes to SYNC.
- The boundary that exposed the error may itself be the left-start; SYNC accepts it on that same rise, so no extra frame is lost.

Enable:
- enable=0 at any clk: next clk FSM=IDLE; the pending pair is dropped; no out_valid or frame_err.
- out_l/out_r keep their last values.

Simultaneous events:
- A boundary and enable falling on the same clk: enable wins, so no output.

Optional Feature:
- Macro: I2S_RX_LJ_EN.
- Defined: fmt_lj selects left-justified timing (no one-bit delay).
  - fmt_lj is sampled only in IDLE/SYNC.
  - A change of fmt_lj during LEFT/RIGHT forces SYNC with no output.
- Undefined: fmt_lj is ignored; the block is always I2S; no format mux is synthesised.

Test Plan:
- I2S, 32-bit slots, L=0x123456 + 8 zero bits, R=0xABCDEF + 8 zero bits, starting at a left-slot boundary → one out_valid pulse, out_l=0x123456, out_r=0xABCDEF, frame_err never asserted.
- 16-bit slots, L=0x8001, R=0x7FFF → out_l=0x800100, out_r=0x7FFF00; 4 consecutive frames → exactly 4 out_valid pulses.
- Stream begins mid right-slot → partial discarded; first out_valid carries the first complete frame only.
- 8-bit right slot inside 32-bit frames → frame_err pulse, no out_valid for that frame; the next valid frame is output correctly.
- enable dropped mid-left-slot, then re-raised → no output for the interrupted frame; resync; next full frame is output; rst_n low mid-frame → all outputs 0 next clk.
- With I2S_RX_LJ_EN and fmt_lj=1, L=0x000001, R=0xFFFFFF in LJ timing → out_l=0x000001, out_r=0xFFFFFF.
